// File: rtl/pong_pkg.sv
// Shared Pong definitions: game state encoding, direction codes and default playfield geometry,
// so the ball engine, paddle controllers and renderer all agree on one layout.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam int DEF_COORD_W     = 10;
  localparam int DEF_SCORE_W     = 4;
  localparam int DEF_LEFT_FACE   = 155;
  localparam int DEF_RIGHT_FACE  = 775;
  localparam int DEF_TOP_WALL    = 45;
  localparam int DEF_BOT_WALL    = 505;
  localparam int DEF_CENTER_X    = 464;
  localparam int DEF_CENTER_Y    = 275;
  localparam int DEF_BALL_HALF   = 8;
  localparam int DEF_PADDLE_HALF = 50;
  localparam int DEF_SPEED_MAX   = 4;
  localparam int DEF_SERVE_TICKS = 60;
  localparam int DEF_WIN_SCORE   = 9;

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational window compare: ball y within +/-WINDOW (inclusive) of paddle centre y.
// Zero latency, no flow control.
module paddle_hit_check #(
  parameter int COORD_W = 10,
  parameter int WINDOW  = 58
) (
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle_y,
  output logic               in_window
);

  logic [COORD_W-1:0] diff;

  always_comb begin
    diff      = (ball_y >= paddle_y) ? (ball_y - paddle_y) : (paddle_y - ball_y);
    in_window = (32'(diff) <= 32'(WINDOW));
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Pong ball engine: serve/play/game-over sequencing, wall and paddle bounces, speed-up and scoring.
// Registered outputs; a tick's effect shows the next cycle and cycles without tick hold all state.
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int LEFT_FACE   = DEF_LEFT_FACE,
  parameter int RIGHT_FACE  = DEF_RIGHT_FACE,
  parameter int TOP_WALL    = DEF_TOP_WALL,
  parameter int BOT_WALL    = DEF_BOT_WALL,
  parameter int CENTER_X    = DEF_CENTER_X,
  parameter int CENTER_Y    = DEF_CENTER_Y,
  parameter int BALL_HALF   = DEF_BALL_HALF,
  parameter int PADDLE_HALF = DEF_PADDLE_HALF,
  parameter int SPEED_MAX   = DEF_SPEED_MAX,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic [COORD_W-1:0] yposLeft,
  input  logic [COORD_W-1:0] yposRight,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic [SCORE_W-1:0] scoreLeft,
  output logic [SCORE_W-1:0] scoreRight,
  output logic               serving,
  output logic               game_over,
  output logic               winner,
  output logic               hit,
  output logic               miss
);

  localparam int SW    = COORD_W + 2;
  localparam int CNT_W = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam int SPD_W = $clog2(SPEED_MAX + 1);

  typedef logic signed [SW-1:0] scoord_t;

  localparam scoord_t MAX_C   = scoord_t'((1 << COORD_W) - 1);
  localparam scoord_t BH_S    = scoord_t'(BALL_HALF);
  localparam scoord_t TOP_S   = scoord_t'(TOP_WALL);
  localparam scoord_t BOT_S   = scoord_t'(BOT_WALL);
  localparam scoord_t LEFT_S  = scoord_t'(LEFT_FACE);
  localparam scoord_t RIGHT_S = scoord_t'(RIGHT_FACE);

  localparam logic [COORD_W-1:0] CX      = COORD_W'(CENTER_X);
  localparam logic [COORD_W-1:0] CY      = COORD_W'(CENTER_Y);
  localparam logic [COORD_W-1:0] Y_TOPRB = COORD_W'(TOP_WALL + BALL_HALF + 1);
  localparam logic [COORD_W-1:0] Y_BOTRB = COORD_W'(BOT_WALL - BALL_HALF - 1);
  localparam logic [COORD_W-1:0] X_LRB   = COORD_W'(LEFT_FACE + BALL_HALF + 1);
  localparam logic [COORD_W-1:0] X_RRB   = COORD_W'(RIGHT_FACE - BALL_HALF - 1);
  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_INI = CNT_W'(SERVE_TICKS);
  localparam logic [SPD_W-1:0]   SPD_ONE = SPD_W'(1);
  localparam logic [SPD_W-1:0]   SPD_TOP = SPD_W'(SPEED_MAX);

  function automatic logic [COORD_W-1:0] clamp(input scoord_t v);
    if (v < scoord_t'(0))  return '0;
    else if (v > MAX_C)    return '1;
    else                   return v[COORD_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic xdir_q, xdir_d, ydir_q, ydir_d, winner_q, winner_d;
  logic hit_q, hit_d, miss_q, miss_d, serving_q, serving_d, over_q, over_d;

  scoord_t            step, nx, ny;
  logic               pad_l, pad_r, point_l, point_r;
  logic [SCORE_W-1:0] sl_inc, sr_inc;
  logic [SPD_W-1:0]   spd_up;

  paddle_hit_check #(.COORD_W(COORD_W), .WINDOW(PADDLE_HALF + BALL_HALF)) u_hit_l (
    .ball_y(ypos_q), .paddle_y(yposLeft), .in_window(pad_l)
  );
  paddle_hit_check #(.COORD_W(COORD_W), .WINDOW(PADDLE_HALF + BALL_HALF)) u_hit_r (
    .ball_y(ypos_q), .paddle_y(yposRight), .in_window(pad_r)
  );

  // Two guard bits keep candidate positions signed so edge compares never wrap.
  always_comb begin
    step   = $signed({{(SW-SPD_W){1'b0}}, speed_q});
    nx     = (xdir_q == DIR_RIGHT) ? $signed({2'b00, xpos_q}) + step : $signed({2'b00, xpos_q}) - step;
    ny     = (ydir_q == DIR_DOWN)  ? $signed({2'b00, ypos_q}) + step : $signed({2'b00, ypos_q}) - step;
    sl_inc = score_l_q + 1'b1;
    sr_inc = score_r_q + 1'b1;
    spd_up = (speed_q >= SPD_TOP) ? SPD_TOP : speed_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    speed_d   = speed_q;
    cnt_d     = cnt_q;
    xdir_d    = xdir_q;
    ydir_d    = ydir_q;
    winner_d  = winner_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    point_l   = 1'b0;
    point_r   = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d   = SERVE;
          score_l_d = '0;
          score_r_d = '0;
          speed_d   = SPD_ONE;
          cnt_d     = CNT_INI;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (ny - BH_S <= TOP_S) begin
            ypos_d = Y_TOPRB;
            ydir_d = DIR_DOWN;
          end else if (ny + BH_S >= BOT_S) begin
            ypos_d = Y_BOTRB;
            ydir_d = DIR_UP;
          end else begin
            ypos_d = clamp(ny);
          end
          xpos_d = clamp(nx);
          if (nx - BH_S <= LEFT_S) begin
            if (pad_l) begin
              xpos_d  = X_LRB;
              xdir_d  = DIR_RIGHT;
              speed_d = spd_up;
              hit_d   = 1'b1;
            end else begin
              point_r = 1'b1;
            end
          end else if (nx + BH_S >= RIGHT_S) begin
            if (pad_r) begin
              xpos_d  = X_RRB;
              xdir_d  = DIR_LEFT;
              speed_d = spd_up;
              hit_d   = 1'b1;
            end else begin
              point_l = 1'b1;
            end
          end
          // A point recentres the ball, so it overrides the vertical update above.
          if (point_l || point_r) begin
            miss_d  = 1'b1;
            speed_d = SPD_ONE;
            xpos_d  = CX;
            ypos_d  = CY;
            ydir_d  = ~ydir_q;
            xdir_d  = point_r ? DIR_LEFT : DIR_RIGHT;
            if (point_r) score_r_d = sr_inc;
            else         score_l_d = sl_inc;
            if (point_r ? (sr_inc == WIN_S) : (sl_inc == WIN_S)) begin
              state_d  = GAME_OVER;
              winner_d = point_r;
            end else begin
              state_d = SERVE;
              cnt_d   = CNT_INI;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    serving_d = (state_d == SERVE);
    over_d    = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      xpos_q    <= CX;
      ypos_q    <= CY;
      score_l_q <= '0;
      score_r_q <= '0;
      speed_q   <= SPD_ONE;
      cnt_q     <= '0;
      xdir_q    <= DIR_RIGHT;
      ydir_q    <= DIR_UP;
      winner_q  <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      serving_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      xdir_q    <= xdir_d;
      ydir_q    <= ydir_d;
      winner_q  <= winner_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      serving_q <= serving_d;
      over_q    <= over_d;
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign scoreLeft  = score_l_q;
  assign scoreRight = score_r_q;
  assign serving    = serving_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: a vector table for the opening rally, then hand sequences
// for the corner bounce, speed saturation, game over and asynchronous reset.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] yl = 10'd275, yr = 10'd275;
  logic [9:0] cyl = 10'd54, cyr = 10'd54;
  logic [9:0] xpos, ypos, cx, cy;
  logic [3:0] sl, sr, csl, csr;
  logic       srv, go, win, hit, miss;
  logic       csrv, cgo, cwin, chit, cmiss;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .yposLeft(yl), .yposRight(yr), .xpos(xpos), .ypos(ypos),
    .scoreLeft(sl), .scoreRight(sr), .serving(srv), .game_over(go),
    .winner(win), .hit(hit), .miss(miss)
  );

  // Narrow court so the right-paddle return and the top-wall bounce land on the same tick.
  ball_motion_ctrl #(.CENTER_X(300), .RIGHT_FACE(530)) dut_c (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .yposLeft(cyl), .yposRight(cyr), .xpos(cx), .ypos(cy),
    .scoreLeft(csl), .scoreRight(csr), .serving(csrv), .game_over(cgo),
    .winner(cwin), .hit(chit), .miss(cmiss)
  );

  typedef struct {
    int idle; bit st; int nt; int yl; int yr;
    int ex; int ey; bit esrv; bit ehit; bit emiss; int esl; int esr;
  } vec_t;

  vec_t v[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      yl = 10'(v[i].yl);
      yr = 10'(v[i].yr);
      repeat (v[i].idle) @(negedge clk);
      if (v[i].st) do_start();
      repeat (v[i].nt) do_tick();
      chk($sformatf("v%0d_xpos", i), xpos, v[i].ex);
      chk($sformatf("v%0d_ypos", i), ypos, v[i].ey);
      chk($sformatf("v%0d_serving", i), srv, v[i].esrv);
      chk($sformatf("v%0d_hit", i), hit, v[i].ehit);
      chk($sformatf("v%0d_miss", i), miss, v[i].emiss);
      chk($sformatf("v%0d_scoreL", i), sl, v[i].esl);
      chk($sformatf("v%0d_scoreR", i), sr, v[i].esr);
      chk($sformatf("v%0d_game_over", i), go, 0);
    end
  endtask

  initial begin
    int nh, exp_spd, prevx, dx, guard, nm;
    bit wait_step;

    //        idle st  nt  yl   yr   x    y   srv hit miss sL sR
    v[0]  = '{0,   0,  0, 275, 275, 464, 275, 0, 0, 0, 0, 0};
    v[1]  = '{0,   0,  5, 275, 275, 464, 275, 0, 0, 0, 0, 0};
    v[2]  = '{0,   1,  0, 275, 275, 464, 275, 1, 0, 0, 0, 0};
    v[3]  = '{100, 0,  0, 275, 275, 464, 275, 1, 0, 0, 0, 0};
    v[4]  = '{0,   0, 59, 275, 275, 464, 275, 1, 0, 0, 0, 0};
    v[5]  = '{0,   0,  1, 275, 275, 464, 275, 0, 0, 0, 0, 0};
    v[6]  = '{0,   0,  1, 275, 275, 465, 274, 0, 0, 0, 0, 0};
    v[7]  = '{0,   0,220, 275, 275, 685,  54, 0, 0, 0, 0, 0};
    v[8]  = '{0,   0,  1, 275, 275, 686,  54, 0, 0, 0, 0, 0};
    v[9]  = '{0,   0,  1, 275, 275, 687,  55, 0, 0, 0, 0, 0};
    v[10] = '{0,   0, 79, 275, 192, 766, 134, 0, 0, 0, 0, 0};
    v[11] = '{0,   0,  1, 275, 192, 766, 135, 0, 1, 0, 0, 0};
    v[12] = '{0,   0,  1, 275, 192, 764, 137, 0, 0, 0, 0, 0};
    v[13] = '{100, 0,  0, 275, 192, 764, 137, 0, 0, 0, 0, 0};
    v[14] = '{0,   0,300, 315, 275, 164, 256, 0, 0, 0, 0, 0};
    v[15] = '{0,   0,  1, 315, 275, 464, 275, 1, 0, 1, 0, 1};
    v[16] = '{0,   0, 60, 275, 275, 464, 275, 0, 0, 0, 0, 1};
    v[17] = '{0,   0,  1, 275, 275, 463, 276, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_winner", win, 0);

    run_rows(0, 8);
    chk("corner_x", cx, 521);
    chk("corner_y", cy, 54);
    chk("corner_hit", chit, 1);
    chk("corner_miss", cmiss, 0);
    run_rows(9, 9);
    chk("corner_next_x", cx, 519);
    chk("corner_next_y", cy, 56);
    chk("corner_scores", {csl, csr}, 0);
    chk("corner_flags", {csrv, cgo, cwin}, 0);
    run_rows(10, 17);

    // Both paddles follow the ball: every approach is a return and speed climbs to its cap.
    nh = 0; exp_spd = 0; guard = 0; wait_step = 1'b0;
    while ((nh < 8 || wait_step) && guard < 5000) begin
      yl = ypos;
      yr = ypos;
      prevx = int'(xpos);
      do_tick();
      guard++;
      if (wait_step) begin
        dx = int'(xpos) - prevx;
        if (dx < 0) dx = -dx;
        chk($sformatf("step_after_hit%0d", nh), dx, exp_spd);
        wait_step = 1'b0;
      end
      if (miss) chk("track_no_miss", miss, 0);
      if (hit) begin
        nh++;
        exp_spd = (nh + 1 > 4) ? 4 : nh + 1;
        wait_step = 1'b1;
      end
    end
    if (guard >= 5000) expire("track_hits");

    // Left keeps returning, right always misses: scoreLeft climbs to the winning score.
    nm = 0; guard = 0;
    while (!go && guard < 20000) begin
      yl = ypos;
      yr = (ypos < 10'd275) ? 10'd1000 : 10'd0;
      do_tick();
      guard++;
      if (miss) begin
        nm++;
        chk("scoreL_step", sl, nm);
      end
    end
    if (guard >= 20000) expire("game_over_wait");
    chk("go_misses", nm, 9);
    chk("go_flag", go, 1);
    chk("go_winner", win, 0);
    chk("go_scoreL", sl, 9);
    chk("go_scoreR", sr, 1);
    chk("go_miss_pulse", miss, 1);
    chk("go_xpos", xpos, 464);
    chk("go_ypos", ypos, 275);
    chk("go_serving", srv, 0);

    repeat (10) do_tick();
    chk("frozen_xpos", xpos, 464);
    chk("frozen_ypos", ypos, 275);
    chk("frozen_scoreL", sl, 9);
    chk("frozen_go", go, 1);

    do_start();
    chk("restart_scoreL", sl, 0);
    chk("restart_scoreR", sr, 0);
    chk("restart_serving", srv, 1);
    chk("restart_go", go, 0);

    repeat (65) do_tick();
    chk("pre_reset_xpos", xpos, 469);
    chk("pre_reset_serving", srv, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_xpos", xpos, 464);
    chk("arst_ypos", ypos, 275);
    chk("arst_flags", {srv, go, hit, miss}, 0);
    chk("arst_scores", {sl, sr}, 0);
    @(negedge clk) rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Parametrised ball-motion engine for the Pong datapath, the successor to the fixed-geometry ball mover. It sits between the paddle controllers and the VGA renderer and produces the ball centre and both scores. It adds a frame-tick enable, a serve/play/game-over state machine, ball speed that rises after paddle hits, and win detection. All playfield geometry is set by parameters.

Parameters:
COORD_W, 10, width of all coordinates
SCORE_W, 4, width of each score counter
LEFT_FACE, 155, x of the left paddle contact plane
RIGHT_FACE, 775, x of the right paddle contact plane
TOP_WALL, 45, y of the top wall
BOT_WALL, 505, y of the bottom wall
CENTER_X, 464, serve x position
CENTER_Y, 275, serve y position
BALL_HALF, 8, ball half-size
PADDLE_HALF, 50, paddle half-height
SPEED_MAX, 4, maximum pixels moved per tick per axis (>=1)
SERVE_TICKS, 60, ticks the ball is held at centre before a serve
WIN_SCORE, 9, score that ends the game (< 2^SCORE_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle movement strobe (frame rate); no motion or countdown without it
start  in  1  level; leaves IDLE or GAME_OVER
yposLeft  in  COORD_W  left paddle centre y
yposRight  in  COORD_W  right paddle centre y
xpos  out  COORD_W  ball centre x
ypos  out  COORD_W  ball centre y
scoreLeft  out  SCORE_W  left player score
scoreRight  out  SCORE_W  right player score
serving  out  1  high in SERVE
game_over  out  1  high in GAME_OVER
winner  out  1  0 = left won, 1 = right won; valid while game_over is high
hit  out  1  one-cycle pulse on a paddle return
miss  out  1  one-cycle pulse when a point is scored

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, xpos=CENTER_X, ypos=CENTER_Y, scores=0, speed=1.
  - xdir=1 (right), ydir=0 (up); all pulse and flag outputs are 0.
- All outputs are registered. The effect of a tick appears on the cycle after the tick. Cycles without tick hold all state; pulses last one clk cycle.
- State machine:
  - IDLE: start=1 -> SERVE. Scores cleared, speed=1, countdown=SERVE_TICKS.
  - SERVE: ball is held at centre. Each tick decrements the countdown; the tick that takes it to 0 -> PLAY.
  - PLAY: on each tick, step both axes by speed in the current directions.
  - GAME_OVER: ball is held at centre. start=1 -> IDLE path (scores cleared, then SERVE).
- Arithmetic:
  - Candidate positions are computed in COORD_W+2 signed bits, so subtraction can never wrap. This fixes the underflow hazard of the old unsigned compares.
  - Outputs are clamped into range before they are registered.
- Vertical axis:
  - If ny-BALL_HALF <= TOP_WALL: ypos = TOP_WALL+BALL_HALF+1, ydir=1.
  - If ny+BALL_HALF >= BOT_WALL: ypos = BOT_WALL-BALL_HALF-1, ydir=0.
- Horizontal axis, left side: applies when nx-BALL_HALF <= LEFT_FACE.
  - Hit when |ypos-yposLeft| <= PADDLE_HALF+BALL_HALF (inclusive), using the current ypos.
  - On hit: xpos = LEFT_FACE+BALL_HALF+1, xdir=1, speed = min(speed+1, SPEED_MAX), hit pulse.
  - On miss: scoreRight += 1, miss pulse, speed=1, ball returns to centre, go to SERVE with the next serve heading left (xdir=0).
- Horizontal axis, right side: mirror of the left using RIGHT_FACE and yposRight.
  - A miss increments scoreLeft; the next serve heads right.
- Serve vertical direction: ydir toggles on every serve.
- Simultaneous events:
  - A wall and a paddle event in the same tick both apply; this is the corner bounce.
  - A miss overrides the vertical update, since the ball recentres.
- Win detection: if the incremented score equals WIN_SCORE -> GAME_OVER instead of SERVE. winner is set to the scoring side, and scores freeze.
- start while in SERVE or PLAY is ignored.
- Reset asserted mid-rally takes effect immediately. Deassertion is synchronised externally.

Decomposition:
- Shared package pong_pkg holds:
  - state enum {IDLE, SERVE, PLAY, GAME_OVER}
  - direction constants DIR_LEFT/RIGHT/UP/DOWN
  - default geometry constants, so the renderer and paddle blocks share the same values.
- One sub-module, paddle_hit_check: combinational window compare of ball y against paddle y. It is instantiated twice, once per side.

Test Plan:
1. Reset, then start=1, then 60 ticks -> serving is high for exactly 60 ticks. The ball stays at (464,275), then moves to (465,274) on the first PLAY tick.
2. Force the ball to the left with yposLeft=275, ypos=275 -> hit pulse. xpos=164, xdir=right, speed becomes 2, and the next tick moves by 2.
3. Same approach with yposLeft=400 (|diff|=125 > 58) -> miss pulse. scoreRight 0->1, ball at centre, serving=1, next serve heads left.
4. Ball moving up near the top wall -> ypos clamps to 54 and ydir flips. A corner case with a paddle hit in the same tick flips both directions.
5. Eight successive hits -> speed saturates at 4 and never exceeds it. tick held low for 100 cycles -> no output changes.
6. scoreLeft=8, then a right-side miss -> scoreLeft=9, game_over=1, winner=0, ball frozen. start=1 -> scores become 0 and state is SERVE. Asserting rst_n=0 mid-PLAY -> outputs return to reset values asynchronously.
